// File: rtl/nios_cpu_div_pkg.sv
// rtl/nios_cpu_div_pkg.sv - shared constants and helpers for the Nios DIV/DIVU cell
// Contents:
//   MAX_WIDTH     widest operand the helpers support
//   DIV_ITERS     default operand width, which is also the restoring iteration count
//   IDLE/ITER/FIX divider FSM state encodings
//   DIV_ZERO_QUOT quotient returned for a zero divisor (all ones)
//   negate()      two's-complement negation at MAX_WIDTH; callers truncate to their width
package nios_cpu_div_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] v);
    return ~v + MAX_WIDTH'(1);
  endfunction

endpackage

// File: rtl/nios_cpu_div_step.sv
// rtl/nios_cpu_div_step.sv - one combinational restoring-division step
// Ports:
//   rem       in  DATA_WIDTH  partial remainder before the step
//   dvd_msb   in  1           dividend bit shifted into the remainder
//   divisor   in  DATA_WIDTH  divisor magnitude
//   rem_next  out DATA_WIDTH  partial remainder after the step
//   q_bit     out 1           quotient bit produced by this step
module nios_cpu_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  // The incoming remainder is always below the divisor, so shifted < 2*divisor:
  // a non-negative trial fits in DATA_WIDTH bits and the top bit is a true sign.
  // A zero divisor breaks that bound, but its result is overridden in FIX.
  assign shifted  = {rem, dvd_msb};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[DATA_WIDTH];
  assign rem_next = q_bit ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/nios_cpu_div_cell.sv
// rtl/nios_cpu_div_cell.sv - iterative radix-2 restoring divider for Nios DIV/DIVU
// Ports:
//   clk          in  1           rising-edge clock
//   reset        in  1           synchronous active-high reset
//   E_src1       in  DATA_WIDTH  dividend
//   E_src2       in  DATA_WIDTH  divisor
//   div_signed   in  1           1 = DIV (two's complement), 0 = DIVU; sampled with start
//   start        in  1           request pulse, accepted only while not busy
//   kill         in  1           pipeline flush, aborts the operation in flight
//   busy         out 1           operation in flight (ITER or FIX)
//   done         out 1           one-cycle pulse, results valid in the same cycle
//   div_quot     out DATA_WIDTH  quotient, held until the next done
//   div_rem      out DATA_WIDTH  remainder, held until the next done
//   div_by_zero  out 1           zero-divisor flag, held until the next done
module nios_cpu_div_cell
  import nios_cpu_div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_ITERS,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] E_src1,
  input  logic [DATA_WIDTH-1:0] E_src2,
  input  logic                  div_signed,
  input  logic                  start,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] div_quot,
  output logic [DATA_WIDTH-1:0] div_rem,
  output logic                  div_by_zero
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] dvd;     // dividend magnitude, becomes the quotient as bits shift in
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] dsr;
  logic [DATA_WIDTH-1:0] raw1;    // unmodified dividend, returned as remainder on divide by zero
  logic                  sign1;
  logic                  sign2;
  logic                  sgn;
  logic                  dbz;

  logic [DATA_WIDTH-1:0] abs1;
  logic [DATA_WIDTH-1:0] abs2;
  logic [DATA_WIDTH-1:0] rem_next;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] quot_fixed;
  logic [DATA_WIDTH-1:0] rem_fixed;

  // |0x80..0| stays 0x80..0 as an unsigned magnitude, which is what the datapath wants.
  assign abs1 = (div_signed && E_src1[DATA_WIDTH-1]) ? DATA_WIDTH'(negate(MAX_WIDTH'(E_src1))) : E_src1;
  assign abs2 = (div_signed && E_src2[DATA_WIDTH-1]) ? DATA_WIDTH'(negate(MAX_WIDTH'(E_src2))) : E_src2;

  assign quot_fixed = (sgn && (sign1 != sign2)) ? DATA_WIDTH'(negate(MAX_WIDTH'(dvd))) : dvd;
  assign rem_fixed  = (sgn && sign1) ? DATA_WIDTH'(negate(MAX_WIDTH'(rem))) : rem;

  assign busy = (state != IDLE);

  nios_cpu_div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[DATA_WIDTH-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      raw1        <= '0;
      sign1       <= 1'b0;
      sign2       <= 1'b0;
      sgn         <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      div_quot    <= '0;
      div_rem     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            dvd   <= abs1;
            dsr   <= abs2;
            raw1  <= E_src1;
            sign1 <= E_src1[DATA_WIDTH-1];
            sign2 <= E_src2[DATA_WIDTH-1];
            sgn   <= div_signed;
            dbz   <= (E_src2 == '0);
            rem   <= '0;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            dvd <= {dvd[DATA_WIDTH-2:0], q_bit};
            rem <= rem_next;
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == LAST_CNT) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!kill) begin
            done        <= 1'b1;
            div_by_zero <= dbz;
            if (dbz) begin
              div_quot <= DATA_WIDTH'(DIV_ZERO_QUOT);
              div_rem  <= raw1;
            end else begin
              div_quot <= quot_fixed;
              div_rem  <= rem_fixed;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_cpu_div_cell.sv
// tb/tb_nios_cpu_div_cell.sv - self-checking bench for nios_cpu_div_cell
module tb_nios_cpu_div_cell;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] e1;
  logic [W-1:0] e2;
  logic         div_signed;
  logic         start;
  logic         kill;
  logic         busy;
  logic         done;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic         div_by_zero;

  always #5 clk = ~clk;

  nios_cpu_div_cell #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .E_src1      (e1),
    .E_src2      (e2),
    .div_signed  (div_signed),
    .start       (start),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .div_quot    (div_quot),
    .div_rem     (div_rem),
    .div_by_zero (div_by_zero)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the DIV/DIVU rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = W'(sa / sb);
        r  = W'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // Transaction-level model: an accepted request produces a result after a fixed
  // number of busy cycles unless it is flushed; outputs hold between results.
  bit           chk_en = 1'b0;
  bit           m_pend = 1'b0;
  int           m_left = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_quot = '0;
  logic [W-1:0] m_rem  = '0;
  logic         m_dbz  = 1'b0;
  logic [W-1:0] r_quot;
  logic [W-1:0] r_rem;
  logic         r_dbz;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
      m_quot = '0;
      m_rem  = '0;
      m_dbz  = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        if (kill) begin
          m_pend = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_pend = 1'b0;
            m_done = 1'b1;
            m_quot = r_quot;
            m_rem  = r_rem;
            m_dbz  = r_dbz;
          end
        end
      end else if (start && !kill) begin
        ref_div(e1, e2, div_signed, r_quot, r_rem, r_dbz);
        m_pend = 1'b1;
        m_left = W + 1;
      end
      m_busy = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", busy, m_busy);
      chk("cyc done", done, m_done);
      chk("cyc quot", div_quot, m_quot);
      chk("cyc rem", div_rem, m_rem);
      chk("cyc dbz", div_by_zero, m_dbz);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start for one cycle, then scrambles operands to show they were latched.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    e1 = a;
    e2 = b;
    div_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    e1 = $urandom;
    e2 = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  // Called in cycle `from` after issue; returns the cycle in which done was seen.
  task automatic wait_done(input int from, output int n, output int busy_cnt);
    n = from;
    busy_cnt = 0;
    while (!done && n < from + 70) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
  endtask

  task automatic dir_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int n;
    int bc;
    issue(a, b, s);
    wait_done(1, n, bc);
    chk({nm, " latency"}, 64'(n), 64'(W + 2));
    chk({nm, " busy cycles"}, 64'(bc), 64'(W + 1));
    chk({nm, " quot"}, div_quot, eq);
    chk({nm, " rem"}, div_rem, er);
    chk({nm, " dbz"}, div_by_zero, ez);
    chk({nm, " busy at done"}, busy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(1, 20));
      4:       return W'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int bc;
    bit seen;
    int guard;
    logic [W-1:0] a;
    logic [W-1:0] b;

    reset = 1'b1;
    start = 1'b0;
    kill = 1'b0;
    div_signed = 1'b0;
    e1 = '0;
    e2 = '0;
    tick(3);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quot", div_quot, '0);
    chk("reset rem", div_rem, '0);
    chk("reset dbz", div_by_zero, 1'b0);
    reset = 1'b0;
    tick();

    dir_op("divu 100/7", 100, 7, 1'b0, 14, 2, 1'b0);
    dir_op("div -100/7", 32'hFFFF_FF9C, 7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    dir_op("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0);
    dir_op("divu by 0", 32'h1234_5678, 0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    tick(2);

    // Flush mid-iteration: nothing completes and prior results stay put.
    issue(50, 5, 1'b0);
    tick(9);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    seen = 1'b0;
    for (int i = 11; i <= 40; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("kill no done", seen, 1'b0);
    chk("kill busy", busy, 1'b0);
    chk("kill quot held", div_quot, 32'hFFFF_FFFF);
    chk("kill rem held", div_rem, 32'h1234_5678);
    chk("kill dbz held", div_by_zero, 1'b1);
    dir_op("after kill", 50, 5, 1'b0, 10, 0, 1'b0);

    // A second start while busy is dropped; then a start in the done cycle is accepted.
    issue(1000, 10, 1'b0);
    tick(4);
    issue(7, 7, 1'b0);
    wait_done(6, n, bc);
    chk("ignored start latency", 64'(n), 64'(W + 2));
    chk("ignored start quot", div_quot, 100);
    chk("ignored start rem", div_rem, 0);
    issue(200, 3, 1'b1);
    wait_done(1, n, bc);
    chk("b2b latency", 64'(n), 64'(W + 2));
    chk("b2b quot", div_quot, 66);
    chk("b2b rem", div_rem, 2);
    tick();
    chk("no extra done", done, 1'b0);

    // Kill alongside start in idle suppresses the request.
    e1 = 9;
    e2 = 3;
    start = 1'b1;
    kill = 1'b1;
    tick();
    start = 1'b0;
    kill = 1'b0;
    chk("kill beats start", busy, 1'b0);
    tick(2);

    // Reset mid-operation.
    issue(12345, 6, 1'b0);
    tick(19);
    reset = 1'b1;
    start = 1'b1;
    kill = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    kill = 1'b0;
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    chk("midreset quot", div_quot, '0);
    chk("midreset rem", div_rem, '0);
    chk("midreset dbz", div_by_zero, 1'b0);
    tick();

    // Random traffic with stray starts and occasional flushes.
    for (int k = 0; k < 250; k++) begin
      a = pick();
      b = pick();
      issue(a, b, 1'($urandom_range(0, 1)));
      guard = 0;
      while (m_pend && guard < 60) begin
        if ($urandom_range(0, 99) < 2) kill = 1'b1;
        if ($urandom_range(0, 99) < 5) begin
          start = 1'b1;
          e1 = $urandom;
          e2 = $urandom;
        end
        tick();
        kill = 1'b0;
        start = 1'b0;
        guard++;
      end
      if (guard >= 60) chk("rand timeout", 64'(guard), 0);
      if ($urandom_range(0, 9) == 0) begin
        start = 1'b1;
        kill = 1'b1;
        tick();
        start = 1'b0;
        kill = 1'b0;
      end
      tick($urandom_range(0, 2));
    end
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
